// File: rtl/squash_game_ctrl_pkg.sv
// Shared definitions for the squash game-flow sequencer: state encodings, widths,
// core pin bundle and the BCD score increment helper.
package squash_game_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned FRAME_W = 8;
    localparam int unsigned DB_W    = 3;

    localparam logic [SCORE_W-1:0] BCD_MAX = 8'h99;

    typedef enum logic [STATE_W-1:0] {
        ST_ATTRACT = 3'd0,
        ST_SERVE   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_MISS    = 3'd4,
        ST_OVER    = 3'd5
    } state_e;

    typedef struct packed {
        logic new_game_n;
        logic pause_n;
    } core_pins_t;

    // Two-digit BCD increment that sticks at 99
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        if (v == BCD_MAX) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/squash_debounce.sv
// Frame-sampled key debouncer: a run counter of samples disagreeing with the
// current debounced level flips the level once it has seen DEBOUNCE_FRAMES of them.
// press pulses for one cycle on the released->pressed transition.
module squash_debounce
    import squash_game_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic key_n,
    output logic press
);

    logic [DB_W-1:0] run_cnt;
    logic            pressed;
    logic            key_low;

    assign key_low = ~key_n;

    // Run counter, debounced level and press pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
            pressed <= 1'b0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (frame_tick) begin
                if (key_low == pressed) begin
                    run_cnt <= '0;
                end else if (run_cnt == DB_W'(DEBOUNCE_FRAMES - 1)) begin
                    run_cnt <= '0;
                    pressed <= key_low;
                    press   <= key_low;
                end else begin
                    run_cnt <= run_cnt + DB_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/squash_game_ctrl.sv
// Game-flow sequencer for the solo squash playfield core: debounced start/pause keys,
// attract/serve/play/pause/miss/over FSM, BCD score and lives, core control pins.
// Optional high-score register enabled by defining SQUASH_HISCORE_EN.
module squash_game_ctrl
    import squash_game_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter int unsigned LIVES           = 3,
    parameter int unsigned SERVE_FRAMES    = 60,
    parameter int unsigned MISS_FRAMES     = 90
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_key_n,
    input  logic               pause_key_n,
    input  logic               hit,
    input  logic               miss,
    output logic               core_new_game_n,
    output logic               core_pause_n,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic [STATE_W-1:0] state,
    output logic               game_over,
    output logic [SCORE_W-1:0] hiscore
);

    state_e             state_q;
    state_e             state_d;
    logic               start_press;
    logic               pause_press;
    logic               hit_q;
    logic               hit_ev;
    logic [FRAME_W-1:0] frm_cnt;
    logic               score_clr;
    logic               score_inc;
    logic               lives_load;
    logic               lives_dec;
    core_pins_t         pins_c;

    squash_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_start_db (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .key_n      (start_key_n),
        .press      (start_press)
    );

    squash_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_pause_db (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .key_n      (pause_key_n),
        .press      (pause_press)
    );

    assign hit_ev = hit & ~hit_q;
    assign state  = state_q;

    // State register and hit edge detector
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ATTRACT;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit;
        end
    end

    // Next-state, score/lives strobes and core pin decode
    always_comb begin
        state_d    = state_q;
        score_clr  = 1'b0;
        score_inc  = 1'b0;
        lives_load = 1'b0;
        lives_dec  = 1'b0;
        pins_c     = '{new_game_n: 1'b1, pause_n: 1'b1};
        case (state_q)
            ST_ATTRACT: begin
                if (start_press) begin
                    state_d    = ST_SERVE;
                    score_clr  = 1'b1;
                    lives_load = 1'b1;
                end
            end
            ST_SERVE: begin
                pins_c = '{new_game_n: 1'b0, pause_n: 1'b0};
                if (frm_cnt == FRAME_W'(SERVE_FRAMES)) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // miss beats pause beats hit
                if (miss) begin
                    lives_dec = 1'b1;
                    state_d   = (lives > LIVES_W'(1)) ? ST_MISS : ST_OVER;
                end else if (pause_press) begin
                    state_d = ST_PAUSE;
                end else if (hit_ev) begin
                    score_inc = 1'b1;
                end
            end
            ST_PAUSE: begin
                pins_c.pause_n = 1'b0;
                if (pause_press) begin
                    state_d = ST_PLAY;
                end
            end
            ST_MISS: begin
                pins_c.pause_n = 1'b0;
                if (frm_cnt == FRAME_W'(MISS_FRAMES)) begin
                    state_d = ST_SERVE;
                end
            end
            ST_OVER: begin
                pins_c.pause_n = 1'b0;
                if (start_press) begin
                    state_d    = ST_SERVE;
                    score_clr  = 1'b1;
                    lives_load = 1'b1;
                end
            end
            default: begin
                state_d = ST_ATTRACT;
            end
        endcase
    end

    // Frame counter, restarted on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            frm_cnt <= '0;
        end else if (state_d != state_q) begin
            frm_cnt <= '0;
        end else if (frame_tick && (frm_cnt != {FRAME_W{1'b1}})) begin
            frm_cnt <= frm_cnt + FRAME_W'(1);
        end
    end

    // Score and lives
    always_ff @(posedge clk) begin
        if (reset) begin
            score <= '0;
            lives <= '0;
        end else begin
            if (score_clr) begin
                score <= '0;
            end else if (score_inc) begin
                score <= bcd_inc(score);
            end
            if (lives_load) begin
                lives <= LIVES_W'(LIVES);
            end else if (lives_dec) begin
                lives <= (lives > LIVES_W'(1)) ? lives - LIVES_W'(1) : '0;
            end
        end
    end

    // Registered outputs: core pins follow the state by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            core_new_game_n <= 1'b1;
            core_pause_n    <= 1'b1;
            game_over       <= 1'b0;
        end else begin
            core_new_game_n <= pins_c.new_game_n;
            core_pause_n    <= pins_c.pause_n;
            game_over       <= (state_d == ST_OVER);
        end
    end

`ifdef SQUASH_HISCORE_EN
    // High score captured on entry to OVER; survives new games
    always_ff @(posedge clk) begin
        if (reset) begin
            hiscore <= '0;
        end else if ((state_d == ST_OVER) && (state_q != ST_OVER) && (score > hiscore)) begin
            hiscore <= score;
        end
    end
`else
    assign hiscore = '0;
`endif

endmodule

// File: tb/tb_squash_game_ctrl.sv
// Scoreboard bench for squash_game_ctrl: stimulus pushes expected snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_squash_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       start_key_n;
    logic       pause_key_n;
    logic       hit;
    logic       miss;
    logic       core_new_game_n;
    logic       core_pause_n;
    logic [7:0] score;
    logic [1:0] lives;
    logic [2:0] state;
    logic       game_over;
    logic [7:0] hiscore;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic [1:0] pins;
        logic [7:0] sc;
        logic [1:0] lv;
        logic       go;
        logic [7:0] hi;
    } exp_t;

`ifdef SQUASH_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    exp_t       sb_q[$];
    exp_t       cur;
    int         tests = 0;
    int         fails = 0;
    logic       sample_req = 1'b0;
    logic [7:0] exp_hi = 8'h00;

    squash_game_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .frame_tick      (frame_tick),
        .start_key_n     (start_key_n),
        .pause_key_n     (pause_key_n),
        .hit             (hit),
        .miss            (miss),
        .core_new_game_n (core_new_game_n),
        .core_pause_n    (core_pause_n),
        .score           (score),
        .lives           (lives),
        .state           (state),
        .game_over       (game_over),
        .hiscore         (hiscore)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input string fld, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %h expected %h", name, fld, act, exp);
        end
    endtask

    // Monitor: pop one expected snapshot per sample request and compare
    always @(negedge clk) begin
        if (sample_req) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard: got empty queue expected an entry");
            end else begin
                cur = sb_q.pop_front();
                cmp(cur.name, "state", {5'b0, state}, {5'b0, cur.st});
                cmp(cur.name, "pins", {6'b0, core_new_game_n, core_pause_n}, {6'b0, cur.pins});
                cmp(cur.name, "score", score, cur.sc);
                cmp(cur.name, "lives", {6'b0, lives}, {6'b0, cur.lv});
                cmp(cur.name, "game_over", {7'b0, game_over}, {7'b0, cur.go});
                cmp(cur.name, "hiscore", hiscore, cur.hi);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            step(3);
        end
    endtask

    task automatic hit_pulse();
        hit = 1'b1;
        step(5);
        hit = 1'b0;
        step(2);
    endtask

    task automatic miss_pulse();
        miss = 1'b1;
        step(1);
        miss = 1'b0;
    endtask

    task automatic expect_snap(input string name, input logic [2:0] st, input logic [1:0] pins,
                               input logic [7:0] sc, input logic [1:0] lv, input logic go);
        step(2);
        sb_q.push_back('{name, st, pins, sc, lv, go, exp_hi});
        sample_req = 1'b1;
        step(1);
        sample_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start_key_n = 1'b1; pause_key_n = 1'b1;
        hit = 1'b0; miss = 1'b0;
        step(3);
        reset = 1'b0;
        frames(3);
        expect_snap("reset", 3'd0, 2'b11, 8'h00, 2'd0, 1'b0);

        // start press and serve timing
        start_key_n = 1'b0;
        frames(2);
        expect_snap("start_2f", 3'd0, 2'b11, 8'h00, 2'd0, 1'b0);
        frames(1);
        start_key_n = 1'b1;
        expect_snap("serve_entry", 3'd1, 2'b00, 8'h00, 2'd3, 1'b0);
        frames(59);
        expect_snap("serve_59", 3'd1, 2'b00, 8'h00, 2'd3, 1'b0);
        frames(1);
        expect_snap("play_entry", 3'd2, 2'b11, 8'h00, 2'd3, 1'b0);

        // scoring with BCD carry and saturation
        repeat (12) hit_pulse();
        expect_snap("score_12", 3'd2, 2'b11, 8'h12, 2'd3, 1'b0);
        repeat (87) hit_pulse();
        expect_snap("score_99", 3'd2, 2'b11, 8'h99, 2'd3, 1'b0);
        hit_pulse();
        expect_snap("score_sat", 3'd2, 2'b11, 8'h99, 2'd3, 1'b0);

        // misses down to game over
        miss_pulse();
        expect_snap("miss1", 3'd4, 2'b10, 8'h99, 2'd2, 1'b0);
        frames(89);
        expect_snap("miss1_89", 3'd4, 2'b10, 8'h99, 2'd2, 1'b0);
        frames(1);
        expect_snap("miss1_serve", 3'd1, 2'b00, 8'h99, 2'd2, 1'b0);
        frames(60);
        expect_snap("play2", 3'd2, 2'b11, 8'h99, 2'd2, 1'b0);
        miss_pulse();
        expect_snap("miss2", 3'd4, 2'b10, 8'h99, 2'd1, 1'b0);
        frames(90);
        frames(60);
        expect_snap("play3", 3'd2, 2'b11, 8'h99, 2'd1, 1'b0);
        miss_pulse();
        exp_hi = HI_EN ? 8'h99 : 8'h00;
        expect_snap("over", 3'd5, 2'b10, 8'h99, 2'd0, 1'b1);

        // restart from OVER
        start_key_n = 1'b0;
        frames(3);
        start_key_n = 1'b1;
        expect_snap("restart", 3'd1, 2'b00, 8'h00, 2'd3, 1'b0);
        frames(60);
        repeat (3) hit_pulse();
        expect_snap("play_r", 3'd2, 2'b11, 8'h03, 2'd3, 1'b0);

        // miss, hit and pause press in the same cycle
        pause_key_n = 1'b0;
        frames(2);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        miss = 1'b1;
        hit = 1'b1;
        step(1);
        miss = 1'b0;
        hit = 1'b0;
        pause_key_n = 1'b1;
        expect_snap("coincident", 3'd4, 2'b10, 8'h03, 2'd2, 1'b0);
        frames(3);
        expect_snap("coinc_hold", 3'd4, 2'b10, 8'h03, 2'd2, 1'b0);
        frames(87);
        expect_snap("serve_r", 3'd1, 2'b00, 8'h03, 2'd2, 1'b0);
        frames(60);
        expect_snap("play_r2", 3'd2, 2'b11, 8'h03, 2'd2, 1'b0);

        // pause debounce boundary, pause and resume
        pause_key_n = 1'b0;
        frames(2);
        pause_key_n = 1'b1;
        frames(1);
        expect_snap("pause_2f", 3'd2, 2'b11, 8'h03, 2'd2, 1'b0);
        pause_key_n = 1'b0;
        frames(3);
        expect_snap("pause_3f", 3'd3, 2'b10, 8'h03, 2'd2, 1'b0);
        start_key_n = 1'b0;
        frames(3);
        start_key_n = 1'b1;
        expect_snap("pause_start", 3'd3, 2'b10, 8'h03, 2'd2, 1'b0);
        pause_key_n = 1'b1;
        frames(3);
        expect_snap("pause_rel", 3'd3, 2'b10, 8'h03, 2'd2, 1'b0);
        pause_key_n = 1'b0;
        frames(3);
        expect_snap("resume", 3'd2, 2'b11, 8'h03, 2'd2, 1'b0);
        pause_key_n = 1'b1;
        frames(3);
        hit_pulse();
        expect_snap("score_4", 3'd2, 2'b11, 8'h04, 2'd2, 1'b0);

        // reset mid-game
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        exp_hi = 8'h00;
        expect_snap("mid_reset", 3'd0, 2'b11, 8'h00, 2'd0, 1'b0);

        step(2);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
